// File: rtl/lsu_dc_fill_ctl_if.sv
// lsu_dc_fill_ctl_if: miss, system-bus fill and d-cache array signals of the line-fill sequencer
interface lsu_dc_fill_ctl_if #(parameter int NUM_WAYS = 4);
    logic                miss_valid;
    logic [29:0]         miss_addr;
    logic [NUM_WAYS-1:0] miss_way;
    logic                miss_ready;
    logic                flush;
    logic                fill_req_valid;
    logic [26:0]         fill_req_addr;
    logic                fill_req_ready;
    logic                fill_rsp_valid;
    logic [63:0]         fill_rsp_data;
    logic                fill_rsp_err;
    logic                fill_rsp_ready;
    logic                lsu_dc_busy;
    logic [NUM_WAYS-1:0] dc_wr_en;
    logic [29:0]         dc_rw_addr;
    logic [67:0]         dc_wr_data;
    logic [NUM_WAYS-1:0] lsu_dc_tag_wren;
    logic [29:0]         dc_rw_tag_addr;
    logic [NUM_WAYS-1:0] dc_tag_valid;
    logic                fill_done;
    logic                fill_err;
    logic                fill_abort;
    modport master (
        input  miss_valid, miss_addr, miss_way, flush, fill_req_ready, fill_rsp_valid,
               fill_rsp_data, fill_rsp_err, lsu_dc_busy,
        output miss_ready, fill_req_valid, fill_req_addr, fill_rsp_ready, dc_wr_en, dc_rw_addr,
               dc_wr_data, lsu_dc_tag_wren, dc_rw_tag_addr, dc_tag_valid, fill_done, fill_err, fill_abort
    );
    modport slave (
        output miss_valid, miss_addr, miss_way, flush, fill_req_ready, fill_rsp_valid,
               fill_rsp_data, fill_rsp_err, lsu_dc_busy,
        input  miss_ready, fill_req_valid, fill_req_addr, fill_rsp_ready, dc_wr_en, dc_rw_addr,
               dc_wr_data, lsu_dc_tag_wren, dc_rw_tag_addr, dc_tag_valid, fill_done, fill_err, fill_abort
    );
endinterface

// File: rtl/lsu_dc_fill_ctl.sv
// lsu_dc_fill_ctl: d-cache line-fill sequencer (bus line read -> parity-protected beat writes -> victim tag write)
module lsu_dc_fill_ctl #(
    parameter int NUM_WAYS   = 4,
    parameter int LINE_BEATS = 4
) (
    input logic           clk,
    input logic           rst_l,
    lsu_dc_fill_ctl_if.master io
);
    localparam int BW = $clog2(LINE_BEATS);
    typedef enum logic [2:0] {IDLE, REQ, DATA, TAG, DONE} state_t;
    state_t              state_q, state_d;
    logic [26:0]         line_q;
    logic [NUM_WAYS-1:0] way_q;
    logic [BW-1:0]       beat_cnt_q, buf_beat_q;
    logic [63:0]         buf_data_q;
    logic                all_q, buf_v_q, err_q, abort_q;
    logic                take, acc, last, drop, wr, tag_wr, done;
    logic [3:0]          par;
    assign take   = state_q == IDLE && io.miss_valid;
    assign acc    = state_q == DATA && io.fill_rsp_valid && !buf_v_q;
    assign last   = beat_cnt_q == BW'(LINE_BEATS - 1);
    // erroring, aborted and post-error beats are consumed but never reach the buffer
    assign drop   = io.flush || err_q || abort_q || io.fill_rsp_err;
    assign wr     = buf_v_q && !io.lsu_dc_busy && !io.flush;
    assign tag_wr = state_q == TAG && !io.lsu_dc_busy;
    assign done   = state_q == DONE;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = io.miss_valid ? REQ : IDLE;
            REQ:     state_d = io.fill_req_ready ? DATA : io.flush ? DONE : REQ;
            DATA:    state_d = (all_q && !buf_v_q) ? TAG : DATA;
            TAG:     state_d = io.lsu_dc_busy ? TAG : DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        par = '0;
        for (int i = 0; i < 4; i++) par[i] = ^buf_data_q[16*i +: 16];
    end
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= IDLE;
            line_q     <= '0;
            way_q      <= '0;
            beat_cnt_q <= '0;
            buf_beat_q <= '0;
            buf_data_q <= '0;
            all_q      <= 1'b0;
            buf_v_q    <= 1'b0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                line_q <= io.miss_addr[29:3];
                way_q  <= io.miss_way;
            end
            if (acc) begin
                beat_cnt_q <= last ? '0 : beat_cnt_q + 1'b1;
                buf_beat_q <= beat_cnt_q;
                buf_data_q <= io.fill_rsp_data;
            end
            buf_v_q <= (acc && !drop) || (buf_v_q && !wr && !io.flush);
            all_q   <= !done && (all_q || (acc && last));
            err_q   <= !done && (err_q || (acc && io.fill_rsp_err));
            abort_q <= !done && (abort_q || (io.flush && (state_q == REQ || state_q == DATA)));
        end
    end
    assign io.miss_ready      = state_q == IDLE;
    assign io.fill_req_valid  = state_q == REQ;
    assign io.fill_req_addr   = line_q;
    assign io.fill_rsp_ready  = state_q == DATA && !buf_v_q;
    assign io.dc_wr_en        = wr ? way_q : '0;
    assign io.dc_rw_addr      = {line_q, buf_beat_q, 1'b0};
    assign io.dc_wr_data      = {par, buf_data_q};
    assign io.lsu_dc_tag_wren = tag_wr ? way_q : '0;
    assign io.dc_rw_tag_addr  = {line_q, 3'b000};
    assign io.dc_tag_valid    = (tag_wr && !err_q && !abort_q) ? way_q : '0;
    assign io.fill_done       = done;
    assign io.fill_err        = done && err_q;
    assign io.fill_abort      = done && abort_q;
endmodule

// File: tb/tb_lsu_dc_fill_ctl.sv
// tb_lsu_dc_fill_ctl: directed and randomized fills checked against a transaction-level expectation of landed beats and tag writes
module tb_lsu_dc_fill_ctl;
    logic clk = 1'b0;
    logic rst_l = 1'b1;
    always #5 clk = ~clk;
    lsu_dc_fill_ctl_if #(.NUM_WAYS(4)) io();
    lsu_dc_fill_ctl #(.NUM_WAYS(4), .LINE_BEATS(4)) dut (.clk(clk), .rst_l(rst_l), .io(io));
    typedef struct packed {logic [3:0] w; logic [29:0] a; logic [67:0] d;} wr_t;
    wr_t        wq[$];
    logic [3:0] tw_q[$];
    logic [3:0] tv_q[$];
    logic [29:0] ta_q[$];
    int n_cmp = 0, n_bad = 0, nreq = 0, viol = 0;
    bit in_fill = 0;
    always @(negedge clk) if (rst_l) begin
        if (|io.dc_wr_en) wq.push_back({io.dc_wr_en, io.dc_rw_addr, io.dc_wr_data});
        if (|io.lsu_dc_tag_wren) begin
            tw_q.push_back(io.lsu_dc_tag_wren);
            tv_q.push_back(io.dc_tag_valid);
            ta_q.push_back(io.dc_rw_tag_addr);
        end
        if (io.fill_req_valid && io.fill_req_ready) nreq++;
        if ((|io.dc_wr_en && |io.lsu_dc_tag_wren) || ((|io.dc_wr_en || |io.lsu_dc_tag_wren) && io.lsu_dc_busy)
            || (in_fill && io.miss_ready)) viol++;
    end
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    function automatic logic [3:0] par_of(input logic [63:0] x);
        logic [3:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) p[i] = ^x[16*i +: 16];
        return p;
    endfunction
    // mode: 0 clean, 1 bus error on beat k, 2 flush while request pending, 3 flush once k beats have landed
    task automatic do_fill(input logic [29:0] a, input logic [3:0] w, input int mode, input int k,
                           input int busy_pct, input int rdy_pct, input int busy_beat, input logic [63:0] d0);
        logic [63:0] d [4];
        int acc = 0, hold = 0, cyc = 0, done_cyc = 0, nexp;
        int w0 = wq.size(), t0 = tw_q.size(), r0 = nreq;
        bit done = 0, de = 0, da = 0, fl = 0, reqd = 0;
        for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom};
        if (d0 != 64'h0) d[0] = d0;
        io.miss_valid = 1'b1; io.miss_addr = a; io.miss_way = w;
        @(negedge clk);
        chk("miss_ready_idle", io.miss_ready, 1'b1);
        @(posedge clk); #1;
        io.miss_valid = 1'b0; in_fill = 1;
        while (!done && cyc < 400) begin
            cyc++;
            io.fill_req_ready = (mode == 2) ? 1'b0 : ($urandom_range(99) < rdy_pct);
            io.flush = (mode == 2 && cyc == 3) || (mode == 3 && !fl && wq.size() - w0 == k);
            if (io.flush) fl = 1;
            io.lsu_dc_busy = hold > 0 ? 1'b1 : ($urandom_range(99) < busy_pct);
            io.fill_rsp_valid = reqd && acc < 4 && $urandom_range(3) != 0;
            io.fill_rsp_data = d[acc % 4];
            io.fill_rsp_err = mode == 1 && acc == k;
            @(negedge clk);
            if (hold > 0) begin
                chk("rsp_ready_stall", io.fill_rsp_ready, 1'b0);
                chk("wr_en_stall", io.dc_wr_en, 4'b0);
                hold--;
            end
            if (io.fill_req_valid) chk("req_addr", io.fill_req_addr, a[29:3]);
            if (io.fill_req_valid && io.fill_req_ready) reqd = 1;
            if (io.fill_rsp_valid && io.fill_rsp_ready) begin
                if (acc == busy_beat) hold = 5;
                acc++;
            end
            if (io.fill_done) begin done = 1; de = io.fill_err; da = io.fill_abort; done_cyc = cyc; end
            @(posedge clk); #1;
        end
        in_fill = 0;
        io.flush = 1'b0; io.fill_rsp_valid = 1'b0; io.fill_rsp_err = 1'b0; io.lsu_dc_busy = 1'b0;
        io.fill_req_ready = 1'b0;
        chk("done_seen", done, 1'b1);
        chk("miss_ready_after", io.miss_ready, 1'b1);
        chk("req_handshakes", nreq - r0, mode == 2 ? 0 : 1);
        chk("fill_err", de, mode == 1);
        chk("fill_abort", da, mode >= 2);
        if (mode == 2) chk("abort_latency", done_cyc, 4);
        nexp = (mode == 0) ? 4 : (mode == 2) ? 0 : k;
        chk("n_writes", wq.size() - w0, nexp);
        for (int i = 0; i < nexp && w0 + i < wq.size(); i++)
            chk("wr_rec", wq[w0+i], {w, a[29:3], 2'(i), 1'b0, par_of(d[i]), d[i]});
        chk("n_tag", tw_q.size() - t0, mode == 2 ? 0 : 1);
        if (mode != 2 && tw_q.size() > t0) begin
            chk("tag_wren", tw_q[t0], w);
            chk("tag_valid", tv_q[t0], mode == 0 ? w : 4'b0);
            chk("tag_addr", ta_q[t0], {a[29:3], 3'b000});
        end
        if (d0 != 64'h0 && wq.size() > w0) chk("parity_directed", wq[w0].d[67:64], 4'b1000);
    endtask
    initial begin
        int mode, k;
        io.miss_valid = 1'b0; io.miss_addr = '0; io.miss_way = '0; io.flush = 1'b0;
        io.fill_req_ready = 1'b0; io.fill_rsp_valid = 1'b0; io.fill_rsp_data = '0; io.fill_rsp_err = 1'b0;
        io.lsu_dc_busy = 1'b0;
        #1 rst_l = 1'b0;
        #2;
        chk("rst_miss_ready", io.miss_ready, 1'b1);
        chk("rst_outs", {io.fill_req_valid, io.fill_rsp_ready, io.dc_wr_en, io.lsu_dc_tag_wren, io.dc_tag_valid,
                         io.fill_done, io.fill_err, io.fill_abort, io.dc_wr_data, io.dc_rw_addr}, '0);
        @(posedge clk); @(posedge clk); #1 rst_l = 1'b1;
        do_fill(30'h2000_0010, 4'b0010, 0, 0, 0, 100, -1, 64'h0001_0000_0000_0003);
        do_fill(30'h1357_9BD8, 4'b0001, 0, 0, 0, 100, 1, 64'h0);
        do_fill(30'h0246_8AC0, 4'b1000, 1, 2, 0, 100, -1, 64'h0);
        do_fill(30'h3FFF_FFF8, 4'b0100, 2, 0, 0, 100, -1, 64'h0);
        do_fill(30'h0000_0008, 4'b0010, 3, 2, 0, 100, -1, 64'h0);
        for (int n = 0; n < 24; n++) begin
            mode = $urandom_range(3);
            k = (mode == 1) ? $urandom_range(3) : (mode == 3) ? $urandom_range(3, 1) : 0;
            do_fill(30'($urandom), 4'(1 << $urandom_range(3)), mode, k, $urandom_range(50),
                    $urandom_range(100, 30), -1, 64'h0);
        end
        io.miss_valid = 1'b1; io.miss_addr = 30'h0ABC_DEF0; io.miss_way = 4'b0100;
        @(posedge clk); #1;
        io.miss_valid = 1'b0; io.fill_req_ready = 1'b1; io.fill_rsp_valid = 1'b1; io.fill_rsp_data = 64'h1;
        repeat (4) @(posedge clk);
        #3 rst_l = 1'b0;
        #1;
        chk("arst_enables", {io.dc_wr_en, io.lsu_dc_tag_wren, io.fill_req_valid, io.fill_rsp_ready, io.fill_done}, '0);
        io.fill_req_ready = 1'b0; io.fill_rsp_valid = 1'b0;
        @(posedge clk); #1 rst_l = 1'b1;
        #1;
        chk("arst_miss_ready", io.miss_ready, 1'b1);
        chk("arst_req_idle", io.fill_req_valid, 1'b0);
        @(posedge clk); #1;
        do_fill(30'h1111_2220, 4'b0001, 0, 0, 20, 70, -1, 64'h0);
        chk("invariants", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
